// File: rtl/aes_round_ctrl.sv
// Moore FSM that sequences one AES encryption: load, then per round key fetch, SubBytes, ShiftRows/MixColumns, AddRoundKey.
// Optional abort/aborted ports are enabled by defining AES_ROUND_CTRL_ABORT_EN.
module aes_round_ctrl #(
  parameter int NR      = 10,
  parameter int SUB_LAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       rk_ack,
`ifdef AES_ROUND_CTRL_ABORT_EN
  input  logic       abort,
  output logic       aborted,
`endif
  output logic       busy,
  output logic       done,
  output logic [3:0] round,
  output logic       ld_state,
  output logic       rk_req,
  output logic       sb_en,
  output logic       sr_en,
  output logic       mc_en,
  output logic       ark_en
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    KEY  = 3'd2,
    SB   = 3'd3,
    SRMC = 3'd4,
    ARK  = 3'd5,
    DONE = 3'd6
  } state_t;

  localparam logic [3:0] LAST_ROUND = 4'(NR);
  localparam logic [1:0] SB_LAST    = 2'(SUB_LAT - 1);

  state_t     state_reg, state_next;
  logic [3:0] round_reg, round_next;
  logic [1:0] sb_cnt_reg, sb_cnt_next;
`ifdef AES_ROUND_CTRL_ABORT_EN
  logic       aborted_reg, aborted_next;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      round_reg   <= 4'd0;
      sb_cnt_reg  <= 2'd0;
`ifdef AES_ROUND_CTRL_ABORT_EN
      aborted_reg <= 1'b0;
`endif
    end else begin
      state_reg   <= state_next;
      round_reg   <= round_next;
      sb_cnt_reg  <= sb_cnt_next;
`ifdef AES_ROUND_CTRL_ABORT_EN
      aborted_reg <= aborted_next;
`endif
    end
  end

  always_comb begin
    state_next  = state_reg;
    round_next  = round_reg;
    sb_cnt_next = sb_cnt_reg;
`ifdef AES_ROUND_CTRL_ABORT_EN
    aborted_next = 1'b0;
`endif
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = LOAD;
          round_next = 4'd0;
        end
      end
      LOAD: begin
        round_next = 4'd0;
        state_next = KEY;
      end
      KEY: begin
        // Round 0 is the initial key whitening only, so it skips straight to AddRoundKey.
        if (rk_ack) state_next = (round_reg == 4'd0) ? ARK : SB;
      end
      SB: begin
        if (sb_cnt_reg == SB_LAST) begin
          sb_cnt_next = 2'd0;
          state_next  = SRMC;
        end else begin
          sb_cnt_next = sb_cnt_reg + 2'd1;
        end
      end
      SRMC: state_next = ARK;
      ARK: begin
        if (round_reg == LAST_ROUND) begin
          state_next = DONE;
        end else begin
          round_next = round_reg + 4'd1;
          state_next = KEY;
        end
      end
      DONE: begin
        if (start) begin
          state_next = LOAD;
          round_next = 4'd0;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
`ifdef AES_ROUND_CTRL_ABORT_EN
    // Abort overrides every other transition taken while an encryption is in flight.
    if (abort && busy) begin
      state_next   = IDLE;
      round_next   = 4'd0;
      sb_cnt_next  = 2'd0;
      aborted_next = 1'b1;
    end
`endif
  end

  assign busy     = (state_reg == LOAD) || (state_reg == KEY) || (state_reg == SB) ||
                    (state_reg == SRMC) || (state_reg == ARK);
  assign done     = (state_reg == DONE);
  assign round    = round_reg;
  assign ld_state = (state_reg == LOAD);
  assign rk_req   = (state_reg == KEY);
  assign sb_en    = (state_reg == SB);
  assign sr_en    = (state_reg == SRMC);
  assign mc_en    = (state_reg == SRMC) && (round_reg != LAST_ROUND);
  assign ark_en   = (state_reg == ARK);
`ifdef AES_ROUND_CTRL_ABORT_EN
  assign aborted  = aborted_reg;
`endif

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl: directed latency/stall/reset cases plus random traffic against a step-queue model.
module tb_aes_round_ctrl;
  localparam int NR      = 10;
  localparam int SUB_LAT = 1;
`ifdef AES_ROUND_CTRL_ABORT_EN
  localparam bit ABORT_ON = 1'b1;
`else
  localparam bit ABORT_ON = 1'b0;
`endif

  localparam int K_LOAD = 1, K_KEY = 2, K_SB = 3, K_SRMC = 4, K_ARK = 5, K_DONE = 6;

  logic       clk = 1'b0;
  logic       rst, start, rk_ack;
  logic       busy, done, ld_state, rk_req, sb_en, sr_en, mc_en, ark_en;
  logic [3:0] round;
`ifdef AES_ROUND_CTRL_ABORT_EN
  logic       abort, aborted;
`endif

  int total = 0;
  int bad   = 0;

  // Model: the remaining steps of the current encryption, head = what the DUT should be doing now.
  typedef struct { int kind; int rnd; } step_t;
  step_t plan[$];
  int    idle_round = 0;
  logic  exp_aborted = 1'b0;

  aes_round_ctrl #(.NR(NR), .SUB_LAT(SUB_LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .rk_ack(rk_ack),
`ifdef AES_ROUND_CTRL_ABORT_EN
    .abort(abort), .aborted(aborted),
`endif
    .busy(busy), .done(done), .round(round), .ld_state(ld_state), .rk_req(rk_req),
    .sb_en(sb_en), .sr_en(sr_en), .mc_en(mc_en), .ark_en(ark_en)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void push(input int k, input int r);
    step_t s;
    s.kind = k;
    s.rnd  = r;
    plan.push_back(s);
  endfunction

  function automatic void build_plan();
    push(K_LOAD, 0);
    push(K_KEY, 0);
    push(K_ARK, 0);
    for (int r = 1; r <= NR; r++) begin
      push(K_KEY, r);
      for (int j = 0; j < SUB_LAT; j++) push(K_SB, r);
      push(K_SRMC, r);
      push(K_ARK, r);
    end
    push(K_DONE, NR);
  endfunction

  task automatic check_outputs();
    int k;
    logic [7:0] obs, exp;
    k   = (plan.size() == 0) ? 0 : plan[0].kind;
    obs = {busy, done, ld_state, rk_req, sb_en, sr_en, mc_en, ark_en};
    exp = {k != 0 && k != K_DONE, k == K_DONE, k == K_LOAD, k == K_KEY, k == K_SB,
           k == K_SRMC, k == K_SRMC && plan[0].rnd != NR, k == K_ARK};
    chk("outputs", 32'(obs), 32'(exp));
    if (k == 0) chk("round idle", 32'(round), 32'(idle_round));
    else if (k != K_LOAD) chk("round", 32'(round), 32'(plan[0].rnd));
`ifdef AES_ROUND_CTRL_ABORT_EN
    chk("aborted", 32'(aborted), 32'(exp_aborted));
`endif
  endtask

  function automatic void model_advance(input logic s, input logic a, input logic ab);
    int k;
    logic took_abort;
    took_abort = 1'b0;
    if (plan.size() == 0) begin
      if (s) build_plan();
    end else begin
      k = plan[0].kind;
      if (ABORT_ON && ab && k != K_DONE) begin
        plan.delete();
        idle_round = 0;
        took_abort = 1'b1;
      end else if (k == K_KEY && !a) begin
        // waiting for the round key
      end else if (k == K_DONE) begin
        void'(plan.pop_front());
        idle_round = NR;
        if (s) build_plan();
      end else begin
        void'(plan.pop_front());
      end
    end
    exp_aborted = took_abort;
  endfunction

  // Called at a falling edge: check, drive, advance model, move to the next falling edge.
  task automatic step(input logic s, input logic a, input logic ab);
    check_outputs();
    start  = s;
    rk_ack = a;
`ifdef AES_ROUND_CTRL_ABORT_EN
    abort  = ab;
`endif
    model_advance(s, a, ab);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic measure(input string tag, input int exp_cyc, input int stall);
    int cyc, stalled, r3_req;
    logic a;
    step(1'b1, 1'b1, 1'b0);
    cyc = 1; stalled = 0; r3_req = 0;
    while (done !== 1'b1 && cyc < 200) begin
      if (cyc == 1) chk({tag, " ld_state c1"}, 32'(ld_state), 32'd1);
      if (cyc == 3) chk({tag, " ark_en r0 c3"}, 32'({ark_en, round}), 32'h10);
      if (rk_req === 1'b1 && round == 4'd3) r3_req++;
      a = !(rk_req === 1'b1 && round == 4'd3 && stalled < stall);
      if (!a) stalled++;
      step(1'b0, a, 1'b0);
      cyc++;
    end
    chk({tag, " done cycle"}, 32'(cyc), 32'(exp_cyc));
    chk({tag, " busy at done"}, 32'(busy), 32'd0);
    if (stall > 0) chk({tag, " round3 rk_req cycles"}, 32'(r3_req), 32'(stall + 1));
  endtask

  initial begin
    int cyc;
    rst = 1'b0; start = 1'b0; rk_ack = 1'b0;
`ifdef AES_ROUND_CTRL_ABORT_EN
    abort = 1'b0;
`endif
    #1 rst = 1'b1;
    #1;
    chk("reset async outputs", 32'({busy, done, ld_state, rk_req, sb_en, sr_en, mc_en, ark_en, round}), 32'd0);
    @(negedge clk);
    check_outputs();
    rst = 1'b0;

    measure("basic", 44, 0);
    measure("stall r3", 49, 5);

    // Back-to-back encryptions with start held high throughout.
    step(1'b1, 1'b1, 1'b0);
    cyc = 1;
    while (done !== 1'b1 && cyc < 200) begin
      step(1'b1, 1'b1, 1'b0);
      cyc++;
    end
    chk("b2b done cycle", 32'(cyc), 32'd44);
    step(1'b1, 1'b1, 1'b0);
    chk("b2b ld_state c45", 32'(ld_state), 32'd1);
    while (done !== 1'b1 && cyc < 300) begin
      step(1'b0, 1'b1, 1'b0);
      cyc++;
    end
    step(1'b0, 1'b1, 1'b0);

    // Asynchronous reset in the middle of an encryption.
    step(1'b1, 1'b1, 1'b0);
    repeat (19) step(1'b0, 1'b1, 1'b0);
    check_outputs();
    #2 rst = 1'b1;
    #1;
    chk("mid reset outputs", 32'({busy, done, ld_state, rk_req, sb_en, sr_en, mc_en, ark_en, round}), 32'd0);
    plan.delete();
    idle_round  = 0;
    exp_aborted = 1'b0;
    @(negedge clk);
    check_outputs();
    rst = 1'b0;
    step(1'b0, 1'b1, 1'b0);
    measure("post reset", 44, 0);

`ifdef AES_ROUND_CTRL_ABORT_EN
    step(1'b1, 1'b1, 1'b0);
    cyc = 0;
    while (!(sb_en === 1'b1 && round == 4'd5) && cyc < 200) begin
      step(1'b0, 1'b1, 1'b0);
      cyc++;
    end
    chk("abort reached r5 sb", 32'({sb_en, round}), 32'h15);
    step(1'b0, 1'b1, 1'b1);
    chk("abort pulse", 32'({aborted, busy, round}), 32'h20);
    step(1'b0, 1'b1, 1'b0);
    chk("abort single pulse", 32'(aborted), 32'd0);
    repeat (60) step(1'b0, 1'b1, 1'b0);
`endif

    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 7) == 0, $urandom_range(0, 9) < 7, $urandom_range(0, 63) == 0);
    check_outputs();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
